// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Purpose  : Shared types, round constants and sizing helpers for the AES
//            key-expansion engine.
// Revision : 1.0
// ============================================================================
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SUB1 = 3'd1,
        MIX1 = 3'd2,
        SUB2 = 3'd3,
        DONE = 3'd4
    } ks_state_t;

    // Last step of the byte sequencer: four requests, then one collect-only cycle.
    localparam logic [2:0] c_SEQ_LAST = 3'd4;

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] v;
        case (rnd)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1B;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic int nk_of(input int key_bits);
        return key_bits / 32;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_subword_seq.sv
`default_nettype none
// ============================================================================
// Module   : aes_subword_seq
// Purpose  : Five-cycle SubWord sequencer over a shared byte S-box, with
//            optional RotWord achieved through result lane placement.
// Revision : 1.0
// ============================================================================
module aes_subword_seq
    import aes_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_run,
    input  logic        i_rot,
    input  logic [31:0] i_word,
    input  logic [7:0]  i_sbox_data,
    output logic        o_sbox_access,
    output logic [7:0]  o_sbox_data,
    output logic        o_last,
    output logic [31:0] o_col
);

    logic [2:0]  r_k;
    logic [31:0] r_col;
    logic [31:0] w_shifted;
    logic [1:0]  w_bidx;
    logic [1:0]  w_lane;

    assign o_sbox_access = i_run && (r_k < c_SEQ_LAST);
    assign w_shifted     = i_word << {r_k[1:0], 3'b000};
    assign o_sbox_data   = o_sbox_access ? w_shifted[31:24] : 8'h00;
    assign o_last        = i_run && (r_k == c_SEQ_LAST);
    assign o_col         = r_col;

    // Result arriving at step k belongs to the byte requested at step k-1.
    assign w_bidx = r_k[1:0] - 2'd1;
    assign w_lane = i_rot ? (w_bidx + 2'd3) : w_bidx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k   <= 3'd0;
            r_col <= 32'h0;
        end else begin
            if (!i_run || (r_k == c_SEQ_LAST)) begin
                r_k <= 3'd0;
            end else begin
                r_k <= r_k + 3'd1;
            end
            if (i_run && (r_k != 3'd0)) begin
                case (w_lane)
                    2'd0:    r_col[31:24] <= i_sbox_data;
                    2'd1:    r_col[23:16] <= i_sbox_data;
                    2'd2:    r_col[15:8]  <= i_sbox_data;
                    default: r_col[7:0]   <= i_sbox_data;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes_keysched_param.sv
`default_nettype none
// ============================================================================
// Module   : aes_keysched_param
// Purpose  : One-step AES-128/192/256 key expansion sharing an external
//            byte-wide forward S-box.
// Revision : 1.0
// ============================================================================
module aes_keysched_param
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    input  logic [3:0]          round_i,
    input  logic [KEY_BITS-1:0] last_key_i,
    output logic [KEY_BITS-1:0] new_key_o,
    output logic                ready_o,
    output logic                busy_o,
    output logic                sbox_access_o,
    output logic [7:0]          sbox_data_o,
    input  logic [7:0]          sbox_data_i,
    output logic                sbox_decrypt_o
);

    localparam int NK = nk_of(KEY_BITS);

    generate
        if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
            $error("aes_keysched_param: KEY_BITS must be 128, 192 or 256");
        end
    endgenerate

    ks_state_t              r_state;
    logic [KEY_BITS-1:0]    r_key;
    logic [3:0]             r_rnd;
    logic [NK-1:0][31:0]    w_w;
    logic [NK-1:0][31:0]    w_n;
    logic [KEY_BITS-1:0]    w_next;
    logic                   w_run;
    logic                   w_rot;
    logic                   w_last;
    logic [31:0]            w_word;
    logic [31:0]            w_col;

    assign sbox_decrypt_o = 1'b0;
    assign w_run          = (r_state == SUB1) || (r_state == SUB2);
    assign w_rot          = (r_state == SUB1);

    aes_subword_seq u_subword_seq (
        .clk           (clk),
        .rst           (reset),
        .i_run         (w_run),
        .i_rot         (w_rot),
        .i_word        (w_word),
        .i_sbox_data   (sbox_data_i),
        .o_sbox_access (sbox_access_o),
        .o_sbox_data   (sbox_data_o),
        .o_last        (w_last),
        .o_col         (w_col)
    );

    // Word 0 of the window sits in the MSBs. For Nk=8 word 4 restarts the
    // chain from the second SubWord result instead of n3.
    always_comb begin
        w_w = '0;
        w_n = '0;
        for (int j = 0; j < NK; j++) begin
            w_w[j] = r_key[KEY_BITS-1-32*j -: 32];
        end
        w_n[0] = w_w[0] ^ w_col ^ {rcon(r_rnd), 24'h0};
        for (int j = 1; j < NK; j++) begin
            if (NK == 8 && j == 4) begin
                w_n[j] = w_w[j] ^ w_col;
            end else begin
                w_n[j] = w_n[j-1] ^ w_w[j];
            end
        end
    end

    generate
        if (NK == 8) begin : g_nk8
            logic [3:0][31:0] r_nlo;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_nlo <= '0;
                end else if (r_state == MIX1) begin
                    r_nlo <= w_n[3:0];
                end
            end

            assign w_word = (r_state == SUB2) ? r_nlo[3] : w_w[NK-1];
            assign w_next = {r_nlo[0], r_nlo[1], r_nlo[2], r_nlo[3],
                             w_n[4], w_n[5], w_n[6], w_n[7]};
        end else begin : g_nk46
            assign w_word = w_w[NK-1];

            always_comb begin
                w_next = '0;
                for (int j = 0; j < NK; j++) begin
                    w_next[KEY_BITS-1-32*j -: 32] = w_n[j];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_key     <= '0;
            r_rnd     <= 4'd0;
            new_key_o <= '0;
            ready_o   <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            ready_o <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_key   <= last_key_i;
                        r_rnd   <= round_i;
                        busy_o  <= 1'b1;
                        r_state <= SUB1;
                    end
                end
                SUB1: begin
                    if (w_last) begin
                        r_state <= (NK == 8) ? MIX1 : DONE;
                    end
                end
                MIX1: begin
                    r_state <= SUB2;
                end
                SUB2: begin
                    if (w_last) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    new_key_o <= w_next;
                    ready_o   <= 1'b1;
                    busy_o    <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_keysched_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_keysched_param
// Purpose  : Directed self-checking bench for the 128/192/256-bit key
//            expansion engines against FIPS-197 vectors and a small model.
// Revision : 1.0
// ============================================================================
module tb_aes_keysched_param;

    localparam logic [255:0] c_K128  = 256'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [255:0] c_K192  = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] c_K256  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] c_E128  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [191:0] c_E192  = 192'hfe0c91f72402f5a5ec12068e6c827f6b0e7a95b95c56fec2;
    localparam logic [255:0] c_E256  = 256'h9ba354118e6925afa51a8b5f2067fcdea8b09c1a93d194cdbe49846eb75d5b9a;
    localparam logic [127:0] c_E128R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   st;
    logic [3:0]   rnd_in;
    logic [255:0] lk;
    logic [127:0] nk0;
    logic [191:0] nk1;
    logic [255:0] nk2;
    logic [2:0]   rdy, bsy, acc, dec;
    logic [7:0]   sdo0, sdo1, sdo2;
    logic [7:0]   sdi0, sdi1, sdi2;
    logic [7:0]   sbox_tab [256];
    int           n_checks = 0;
    int           n_fail   = 0;

    always #5 clk = ~clk;

    aes_keysched_param #(.KEY_BITS(128)) u_k128 (
        .clk(clk), .reset(reset), .start_i(st[0]), .round_i(rnd_in),
        .last_key_i(lk[127:0]), .new_key_o(nk0), .ready_o(rdy[0]), .busy_o(bsy[0]),
        .sbox_access_o(acc[0]), .sbox_data_o(sdo0), .sbox_data_i(sdi0),
        .sbox_decrypt_o(dec[0]));

    aes_keysched_param #(.KEY_BITS(192)) u_k192 (
        .clk(clk), .reset(reset), .start_i(st[1]), .round_i(rnd_in),
        .last_key_i(lk[191:0]), .new_key_o(nk1), .ready_o(rdy[1]), .busy_o(bsy[1]),
        .sbox_access_o(acc[1]), .sbox_data_o(sdo1), .sbox_data_i(sdi1),
        .sbox_decrypt_o(dec[1]));

    aes_keysched_param #(.KEY_BITS(256)) u_k256 (
        .clk(clk), .reset(reset), .start_i(st[2]), .round_i(rnd_in),
        .last_key_i(lk), .new_key_o(nk2), .ready_o(rdy[2]), .busy_o(bsy[2]),
        .sbox_access_o(acc[2]), .sbox_data_o(sdo2), .sbox_data_i(sdi2),
        .sbox_decrypt_o(dec[2]));

    // Shared S-box: result one cycle after request, stale lookups otherwise.
    always @(posedge clk) begin
        sdi0 <= sbox_tab[sdo0];
        sdi1 <= sbox_tab[sdo1];
        sdi2 <= sbox_tab[sdo2];
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = bb >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox;
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_tab[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbox_tab[x[31:24]], sbox_tab[x[23:16]], sbox_tab[x[15:8]], sbox_tab[x[7:0]]};
    endfunction

    function automatic logic [7:0] model_rcon(input logic [3:0] r);
        logic [7:0] rc = 8'h01;
        if (r == 4'd0 || r > 4'd10) return 8'h00;
        for (int i = 1; i < int'(r); i++) rc = gmul(rc, 8'h02);
        return rc;
    endfunction

    // Standard FIPS-197 expansion of one window; keys are right-aligned.
    function automatic logic [255:0] model(input int nk, input logic [255:0] key, input logic [3:0] r);
        logic [31:0]  w [8];
        logic [31:0]  n [8];
        logic [31:0]  t;
        logic [255:0] res;
        res = '0;
        for (int j = 0; j < 8; j++) begin
            w[j] = 32'h0;
            n[j] = 32'h0;
        end
        for (int j = 0; j < nk; j++) w[j] = key[32*(nk-1-j) +: 32];
        t = w[nk-1];
        t = subw({t[23:0], t[31:24]}) ^ {model_rcon(r), 24'h0};
        n[0] = w[0] ^ t;
        for (int j = 1; j < nk; j++) begin
            if (nk == 8 && j == 4) n[j] = w[j] ^ subw(n[3]);
            else                   n[j] = n[j-1] ^ w[j];
        end
        for (int j = 0; j < nk; j++) res[32*(nk-1-j) +: 32] = n[j];
        return res;
    endfunction

    task automatic run_op(input int sel, input logic [255:0] key, input logic [3:0] r,
                          output logic [255:0] res, output int lat, output int nacc,
                          output bit busy_ok);
        @(negedge clk);
        lk = key;
        rnd_in = r;
        st[sel] = 1'b1;
        @(posedge clk); #1;
        st[sel] = 1'b0;
        lat = 0;
        nacc = 0;
        busy_ok = 1'b1;
        while (lat < 40) begin
            if (acc[sel]) nacc++;
            if (!bsy[sel]) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
            if (rdy[sel]) break;
        end
        if (bsy[sel]) busy_ok = 1'b0;
        res = (sel == 0) ? {128'h0, nk0} : (sel == 1) ? {64'h0, nk1} : nk2;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({nk0, nk1, nk2} !== 576'h0) begin
            n_fail++; $display("FAIL reset_keys: got %h %h %h expected 0", nk0, nk1, nk2);
        end
        n_checks++;
        if ({rdy, bsy, acc, dec} !== 12'h000) begin
            n_fail++; $display("FAIL reset_flags: got rdy=%b bsy=%b acc=%b dec=%b expected 0", rdy, bsy, acc, dec);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({sdo0, sdo1, sdo2, rdy, bsy, acc} !== 33'h0) begin
            n_fail++; $display("FAIL idle_outputs: got sdo=%h/%h/%h rdy=%b bsy=%b acc=%b expected 0",
                               sdo0, sdo1, sdo2, rdy, bsy, acc);
        end
    endtask

    task automatic test_aes128;
        logic [255:0] res; int lat; int na; bit bok;
        run_op(0, c_K128, 4'd1, res, lat, na, bok);
        n_checks++;
        if (res[127:0] !== c_E128) begin
            n_fail++; $display("FAIL aes128_key: got %h expected %h", res[127:0], c_E128);
        end
        n_checks++;
        if (lat !== 6) begin n_fail++; $display("FAIL aes128_latency: got %0d expected 6", lat); end
        n_checks++;
        if (na !== 4) begin n_fail++; $display("FAIL aes128_sbox_count: got %0d expected 4", na); end
        n_checks++;
        if (bok !== 1'b1) begin n_fail++; $display("FAIL aes128_busy: got %b expected 1", bok); end
    endtask

    task automatic test_aes192_start_while_busy;
        int lat; int nrdy;
        @(negedge clk);
        lk = c_K192; rnd_in = 4'd1; st[1] = 1'b1;
        @(posedge clk); #1;
        st[1] = 1'b0;
        @(posedge clk); #1;
        lat = 1;
        lk = 256'h0123456789abcdeffedcba98765432100f1e2d3c4b5a6978; rnd_in = 4'd5; st[1] = 1'b1;
        @(posedge clk); #1;
        lat = 2; st[1] = 1'b0;
        while (lat < 40 && !rdy[1]) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (nk1 !== c_E192) begin n_fail++; $display("FAIL aes192_key: got %h expected %h", nk1, c_E192); end
        n_checks++;
        if (lat !== 6) begin n_fail++; $display("FAIL aes192_latency: got %0d expected 6", lat); end
        nrdy = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (rdy[1]) nrdy++;
        end
        n_checks++;
        if (nrdy !== 0 || bsy[1] !== 1'b0) begin
            n_fail++; $display("FAIL aes192_no_queue: got ready=%0d busy=%b expected 0 0", nrdy, bsy[1]);
        end
    endtask

    task automatic test_aes256;
        logic [255:0] res; int lat; int na; bit bok;
        run_op(2, c_K256, 4'd1, res, lat, na, bok);
        n_checks++;
        if (res !== c_E256) begin n_fail++; $display("FAIL aes256_key: got %h expected %h", res, c_E256); end
        n_checks++;
        if (lat !== 12) begin n_fail++; $display("FAIL aes256_latency: got %0d expected 12", lat); end
        n_checks++;
        if (na !== 8) begin n_fail++; $display("FAIL aes256_sbox_count: got %0d expected 8", na); end
        n_checks++;
        if (bok !== 1'b1) begin n_fail++; $display("FAIL aes256_busy: got %b expected 1", bok); end
    endtask

    task automatic test_back_to_back;
        int r; int cyc;
        @(negedge clk);
        lk = c_K128; rnd_in = 4'd1; st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        r = 1; cyc = 0;
        while (r <= 10 && cyc < 300) begin
            lk[127:0] = {$urandom, $urandom, $urandom, $urandom};
            rnd_in = 4'($urandom);
            @(posedge clk); #1;
            cyc++;
            if (rdy[0]) begin
                if (r < 10) begin
                    lk[127:0] = nk0; rnd_in = 4'(r + 1); st[0] = 1'b1;
                    @(posedge clk); #1;
                    cyc++;
                    st[0] = 1'b0;
                end
                r++;
            end
        end
        n_checks++;
        if (r !== 11) begin n_fail++; $display("FAIL chain_steps: got %0d expected 11", r); end
        n_checks++;
        if (nk0 !== c_E128R10) begin n_fail++; $display("FAIL chain_key: got %h expected %h", nk0, c_E128R10); end
        n_checks++;
        if (cyc !== 69) begin n_fail++; $display("FAIL chain_cycles: got %0d expected 69", cyc); end
    endtask

    task automatic test_rcon_edge;
        logic [255:0] res; logic [255:0] exp; int lat; int na; bit bok;
        run_op(0, c_K128, 4'd0, res, lat, na, bok);
        exp = model(4, c_K128, 4'd0);
        n_checks++;
        if (res !== exp) begin n_fail++; $display("FAIL rcon_round0: got %h expected %h", res, exp); end
        run_op(2, c_K256, 4'd11, res, lat, na, bok);
        exp = model(8, c_K256, 4'd11);
        n_checks++;
        if (res !== exp) begin n_fail++; $display("FAIL rcon_round11: got %h expected %h", res, exp); end
        run_op(1, c_K192, 4'd10, res, lat, na, bok);
        exp = model(6, c_K192, 4'd10);
        n_checks++;
        if (res !== exp) begin n_fail++; $display("FAIL rcon_round10: got %h expected %h", res, exp); end
    endtask

    task automatic test_busy_abort;
        int nrdy; logic [255:0] res; int lat; int na; bit bok;
        @(negedge clk);
        lk = c_K128; rnd_in = 4'd1; st[0] = 1'b1;
        @(posedge clk); #1;
        lk = 256'h00112233445566778899aabbccddeeff; rnd_in = 4'd7;
        @(posedge clk); #1;
        st[0] = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (nk0 !== 128'h0 || nk2 !== 256'h0) begin
            n_fail++; $display("FAIL abort_keys: got %h %h expected 0", nk0, nk2);
        end
        n_checks++;
        if ({bsy[0], acc[0], rdy[0], sdo0} !== 11'h0) begin
            n_fail++; $display("FAIL abort_flags: got bsy=%b acc=%b rdy=%b sdo=%h expected 0",
                               bsy[0], acc[0], rdy[0], sdo0);
        end
        @(negedge clk);
        reset = 1'b0;
        nrdy = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (rdy[0]) nrdy++;
        end
        n_checks++;
        if (nrdy !== 0) begin n_fail++; $display("FAIL abort_no_ready: got %0d expected 0", nrdy); end
        run_op(0, c_K128, 4'd1, res, lat, na, bok);
        n_checks++;
        if (res[127:0] !== c_E128 || lat !== 6) begin
            n_fail++; $display("FAIL abort_restart: got %h lat=%0d expected %h lat=6", res[127:0], lat, c_E128);
        end
        n_checks++;
        if (dec !== 3'b000) begin n_fail++; $display("FAIL sbox_decrypt: got %b expected 000", dec); end
    endtask

    initial begin
        reset  = 1'b1;
        st     = 3'b000;
        rnd_in = 4'd0;
        lk     = '0;
        build_sbox();
        test_reset();
        test_aes128();
        test_aes192_start_while_busy();
        test_aes256();
        test_back_to_back();
        test_rcon_edge();
        test_busy_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_keysched_param.md
Name: aes_keysched_param

Overview:
Parametrised AES key-expansion engine for AES-128, AES-192 and AES-256, selected by KEY_BITS.
- Input: the previous Nk-word key window (Nk = KEY_BITS/32). Output: the next Nk-word window.
- Shares a single byte-wide S-box with the datapath through a request/return port.
- Sits beside the round engine, which drives round_i and start_i and consumes new_key_o.
- Successor to the fixed 128-bit scheduler. It adds the 192/256 modes, the AES-256 extra SubWord pass, input latching and a busy indication.

Parameters:
- KEY_BITS, 128, key window width; legal values 128, 192, 256. Any other value is an elaboration error.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start_i  in  1  request one expansion step; sampled only in IDLE.
- round_i  in  4  expansion step index, selects Rcon.
- last_key_i  in  KEY_BITS  previous window; word 0 = MSBs.
- new_key_o  out  KEY_BITS  next window, registered, held until the next completion.
- ready_o  out  1  one-cycle completion pulse.
- busy_o  out  1  high from start acceptance until ready_o.
- sbox_access_o  out  1  S-box request valid this cycle.
- sbox_data_o  out  8  S-box input byte, 0 when no request.
- sbox_data_i  in  8  S-box result, valid exactly 1 cycle after its request.
- sbox_decrypt_o  out  1  constant 0; the key schedule always uses the forward S-box.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; new_key_o, key_reg, col, byte counter, ready_o, busy_o, sbox_* all 0.
- Rcon(round_i): 1→01, 2→02, 3→04, 4→08, 5→10, 6→20, 7→40, 8→80, 9→1B, 10→36, otherwise 00. It is placed in the MSB byte of the word.
- States: IDLE → SUB1 → (Nk=8 only: MIX1 → SUB2) → DONE → IDLE.
- IDLE: when start_i=1, latch last_key_i into key_reg and round_i into rnd, set busy_o, go to SUB1. Later changes on last_key_i and round_i are ignored.
- SUB1, 5 cycles, counter k=0..4:
  - For k=0..3: sbox_access_o=1 and sbox_data_o = byte k of w[Nk-1], where byte 0 is the MSB.
  - For k=1..4: store sbox_data_i into col.
  - RotWord is achieved by lane placement: the result for byte 0 goes to col[7:0], byte 1 to col[31:24], byte 2 to col[23:16], byte 3 to col[15:8].
  - sbox_access_o=0 at k=4.
- Word generation (all in GF(2), i.e. XOR):
  - n0 = w0 ^ col ^ {Rcon,24'h0}
  - n_j = n_{j-1} ^ w_j for j=1..3; for Nk=6 also j=4,5.
- Nk=8 only:
  - MIX1 (1 cycle): form n0..n3.
  - SUB2 (5 cycles): same schedule as SUB1 on n3, without rotation (byte i goes to lane i), giving col2.
  - Then n4 = w4 ^ col2 and n_j = n_{j-1} ^ w_j for j=5..7. Rcon is not used in this pass.
- DONE: new_key_o <= {n0..n_{Nk-1}}. ready_o=1 for exactly one cycle, busy_o=0, return to IDLE.
- Latency, from the edge that accepts start_i to the first cycle ready_o=1:
  - 6 cycles for Nk=4 and Nk=6.
  - 12 cycles for Nk=8.
- Back-to-back: a start_i seen in the cycle ready_o=1 is accepted, since the block is already in IDLE.
- start_i while busy is ignored; there is no queueing.
- Reset mid-operation aborts immediately. new_key_o clears to 0 and no ready_o is issued.
- The S-box is never requested in IDLE or DONE. sbox_data_o=0 whenever sbox_access_o=0.

Decomposition:
- Package aes_pkg holds:
  - the RCON function/table;
  - the state encoding constants (IDLE, SUB1, MIX1, SUB2, DONE);
  - the function nk_of(KEY_BITS).
- One sub-module, aes_subword_seq: the 5-cycle byte-request/collect sequencer, with a rot input that selects lane placement. It is instantiated once and reused for SUB1 and SUB2.
- The top level holds the FSM, the XOR chain and the output register.

Test Plan:
- KEY_BITS=128, reference-model S-box, last_key 2b7e151628aed2a6abf7158809cf4f3c, round_i=1 → ready_o 6 cycles later; new_key_o = a0fafe1788542cb123a339392a6c7605.
- KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, round_i=1 → new_key_o = fe0c91f72402f5a5ec12068e6c827f6b0e7a95b95c56fec2.
- KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, round_i=1 → ready_o after 12 cycles:
  - new_key_o = 9ba354118e6925afa51a8b5f2067fcdea8b09c1a93d194cdbe49846eb75d5b9a;
  - exactly 8 sbox_access_o cycles.
- Chain the 128-bit case rounds 1..10 with start_i asserted on each ready_o cycle → final window d014f9a8c9ee2589e13f0cc8b6630ca6. last_key_i toggled randomly while busy has no effect.
- Assert start_i again while busy, then assert reset at cycle 3 of SUB1 → no ready_o, all outputs 0 asynchronously; a following start completes normally.
- round_i=0 and round_i=11 → Rcon=00, checked against the model. sbox_decrypt_o stays 0 throughout all tests.
